// File: rtl/pbit_pkg.sv
// Shared types and helpers for the time-multiplexed p-bit sweep engine.
package pbit_pkg;

  localparam int unsigned BETA_FRAC_DEF = 3;
  localparam logic [7:0]  BETA_ONE      = 8'(1 << BETA_FRAC_DEF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_REQ,
    S_ACCUM,
    S_COMPUTE,
    S_UPDATE
  } state_t;

  // Clamp a signed value into the n-bit two's complement range.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x,
                                             input int unsigned        n);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (n - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/pbit_xorshift32.sv
// xorshift32 generator; advances one step per enabled cycle, exposes the low OUT_W bits.
module pbit_xorshift32 #(
  parameter logic [31:0] SEED  = 32'hACE1_2468,
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  output logic [OUT_W-1:0] rnd
);

  logic [31:0] r_state;
  logic [31:0] w_s1;
  logic [31:0] w_s2;
  logic [31:0] w_s3;

  always_comb begin
    w_s1 = r_state ^ (r_state << 13);
    w_s2 = w_s1 ^ (w_s1 >> 17);
    w_s3 = w_s2 ^ (w_s2 << 5);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  r_state <= SEED;
    else if (en)   r_state <= w_s3;
  end

  assign rnd = r_state[OUT_W-1:0];

endmodule

// File: rtl/pbit_tm_sweep_engine.sv
// Time-multiplexed p-bit sweep engine: Gibbs-order row updates from a streamed
// sparse weight/bias row, with beta scaling, clamping and bounded/continuous runs.
module pbit_tm_sweep_engine
  import pbit_pkg::*;
#(
  parameter int unsigned NUM_PBITS = 16,
  parameter int unsigned W_W       = 8,
  parameter int unsigned H_W       = 9,
  parameter int unsigned ACC_W     = 14,
  parameter int unsigned I_W       = 8,
  parameter int unsigned BETA_W    = 8,
  parameter int unsigned BETA_FRAC = 3,
  parameter int unsigned SWEEP_W   = 16,
  parameter int unsigned BIPOLAR   = 0,
  parameter logic [31:0] SEED      = 32'hACE1_2468,
  localparam int unsigned ROW_W    = $clog2(NUM_PBITS)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [SWEEP_W-1:0]   num_sweeps,
  input  logic [BETA_W-1:0]    beta,
  input  logic [NUM_PBITS-1:0] clamp_en,
  input  logic [NUM_PBITS-1:0] clamp_val,
  output logic                 ld_start,
  output logic [ROW_W-1:0]     ld_row,
  input  logic                 ld_valid,
  input  logic [W_W-1:0]       ld_weight,
  input  logic [ROW_W-1:0]     ld_index,
  input  logic [H_W-1:0]       ld_h,
  input  logic                 ld_done,
  output logic                 ld_ack,
  output logic                 busy,
  output logic                 done,
  output logic                 sample_valid,
  output logic [NUM_PBITS-1:0] sample,
  output logic [SWEEP_W-1:0]   sweep_count,
  output logic [I_W-1:0]       dbg_I
);

  state_t                    r_state, w_state_nxt;
  logic [ROW_W-1:0]          r_row, w_row_nxt;
  logic signed [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic signed [H_W-1:0]     r_h, w_h_nxt;
  logic [NUM_PBITS-1:0]      r_m, w_m_nxt;
  logic [NUM_PBITS-1:0]      r_sample, w_sample_nxt;
  logic [SWEEP_W-1:0]        r_nsweeps, w_nsweeps_nxt;
  logic [SWEEP_W-1:0]        r_sweep_cnt, w_sweep_cnt_nxt;
  logic signed [I_W-1:0]     r_dbg_i, w_dbg_i_nxt;
  logic                      r_stop_pend, w_stop_pend_nxt;
  logic                      r_ld_start, w_ld_start_nxt;
  logic                      r_ld_ack, w_ld_ack_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_done, w_done_nxt;
  logic                      r_sval, w_sval_nxt;

  logic                      w_rng_en;
  logic [I_W-1:0]            w_rnd;
  logic signed [31:0]        w_j, w_term, w_acc_sat;
  logic signed [31:0]        w_s1, w_s2, w_beta, w_p, w_i, w_r;
  logic                      w_m_new, w_bit, w_stop;
  logic [SWEEP_W-1:0]        w_cnt_inc;

  pbit_xorshift32 #(
    .SEED  (SEED),
    .OUT_W (I_W)
  ) u_rng (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (w_rng_en),
    .rnd     (w_rnd)
  );

  // Datapath: accumulate term, bias/beta scaling, stochastic compare.
  always_comb begin
    w_j       = 32'(signed'(ld_weight));
    w_term    = r_m[ld_index] ? w_j : ((BIPOLAR != 0) ? -w_j : 32'sd0);
    w_acc_sat = sat(32'(r_acc) + w_term, ACC_W);
    w_s1      = sat(32'(r_acc), H_W + 1);
    w_s2      = sat(w_s1 + 32'(r_h), I_W);
    w_beta    = 32'(signed'({1'b0, beta}));
    w_p       = (w_s2 * w_beta) >>> BETA_FRAC;
    w_i       = sat(w_p, I_W);
    w_r       = 32'(signed'(w_rnd));
    w_m_new   = (32'(r_dbg_i) >= w_r);
    w_bit     = clamp_en[r_row] ? clamp_val[r_row] : w_m_new;
    w_cnt_inc = SWEEP_W'(r_sweep_cnt + 1'b1);
    w_stop    = r_stop_pend | stop;
  end

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_row_nxt       = r_row;
    w_acc_nxt       = r_acc;
    w_h_nxt         = r_h;
    w_m_nxt         = r_m;
    w_sample_nxt    = r_sample;
    w_nsweeps_nxt   = r_nsweeps;
    w_sweep_cnt_nxt = r_sweep_cnt;
    w_dbg_i_nxt     = r_dbg_i;
    w_stop_pend_nxt = r_stop_pend | (stop & r_busy);
    w_busy_nxt      = r_busy;
    w_ld_ack_nxt    = 1'b0;
    w_done_nxt      = 1'b0;
    w_sval_nxt      = 1'b0;
    w_rng_en        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_nsweeps_nxt   = num_sweeps;
          w_sweep_cnt_nxt = '0;
          w_row_nxt       = '0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = S_LOAD_REQ;
        end
      end
      S_LOAD_REQ: begin
        w_acc_nxt   = '0;
        w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        if (ld_valid) w_acc_nxt = ACC_W'(w_acc_sat);
        if (ld_done) begin
          w_h_nxt      = ld_h;
          w_ld_ack_nxt = 1'b1;
          w_state_nxt  = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        w_dbg_i_nxt = I_W'(w_i);
        w_state_nxt = S_UPDATE;
      end
      S_UPDATE: begin
        w_rng_en       = 1'b1;
        w_m_nxt[r_row] = w_bit;
        if (r_row != ROW_W'(NUM_PBITS - 1)) begin
          w_row_nxt   = ROW_W'(r_row + 1'b1);
          w_state_nxt = S_LOAD_REQ;
        end else begin
          w_sample_nxt    = w_m_nxt;
          w_sval_nxt      = 1'b1;
          w_sweep_cnt_nxt = (&r_sweep_cnt) ? r_sweep_cnt : w_cnt_inc;
          w_row_nxt       = '0;
          w_stop_pend_nxt = 1'b0;
          if (((r_nsweeps != '0) && (w_cnt_inc == r_nsweeps)) || w_stop) begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_LOAD_REQ;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_ld_start_nxt = (w_state_nxt == S_LOAD_REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_acc       <= '0;
      r_h         <= '0;
      r_m         <= '0;
      r_sample    <= '0;
      r_nsweeps   <= '0;
      r_sweep_cnt <= '0;
      r_dbg_i     <= '0;
      r_stop_pend <= 1'b0;
      r_ld_start  <= 1'b0;
      r_ld_ack    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sval      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_acc       <= w_acc_nxt;
      r_h         <= w_h_nxt;
      r_m         <= w_m_nxt;
      r_sample    <= w_sample_nxt;
      r_nsweeps   <= w_nsweeps_nxt;
      r_sweep_cnt <= w_sweep_cnt_nxt;
      r_dbg_i     <= w_dbg_i_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_ld_start  <= w_ld_start_nxt;
      r_ld_ack    <= w_ld_ack_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_sval      <= w_sval_nxt;
    end
  end

  assign ld_start     = r_ld_start;
  assign ld_row       = r_row;
  assign ld_ack       = r_ld_ack;
  assign busy         = r_busy;
  assign done         = r_done;
  assign sample_valid = r_sval;
  assign sample       = r_sample;
  assign sweep_count  = r_sweep_cnt;
  assign dbg_I        = r_dbg_i;

endmodule

// File: tb/tb_pbit_tm_sweep_engine.sv
// Directed bench for pbit_tm_sweep_engine: unipolar and bipolar 4-p-bit instances in lockstep.
module tb_pbit_tm_sweep_engine;
  import pbit_pkg::*;

  logic        clk, reset_n, start, stop;
  logic [15:0] num_sweeps;
  logic [7:0]  beta;
  logic [3:0]  clamp_en, clamp_val;
  logic        ld_valid, ld_done;
  logic [7:0]  ld_weight;
  logic [1:0]  ld_index;
  logic [8:0]  ld_h;

  logic        ld_start, ld_ack, busy, done, sample_valid;
  logic [1:0]  ld_row;
  logic [3:0]  sample;
  logic [15:0] sweep_count;
  logic [7:0]  dbg_I;

  logic        b_ld_start, b_ld_ack, b_busy, b_done, b_sample_valid;
  logic [1:0]  b_ld_row;
  logic [3:0]  b_sample;
  logic [15:0] b_sweep_count;
  logic [7:0]  b_dbg_I;

  int          n_tests = 0;
  int          n_fails = 0;

  int          cfg_nbeats = 0;
  logic [7:0]  cfg_w      = '0;
  logic [1:0]  cfg_idx    = '0;
  logic [8:0]  cfg_h      = '0;

  int          res_nsamp, res_ndone, res_nack, res_nrows;
  logic [3:0]  res_first, res_last;
  logic        res_busy_done, res_busy_before;
  logic [7:0]  res_dbg0, res_dbg0_b, res_rows;

  pbit_tm_sweep_engine #(.NUM_PBITS(4)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .num_sweeps(num_sweeps), .beta(beta), .clamp_en(clamp_en), .clamp_val(clamp_val),
    .ld_start(ld_start), .ld_row(ld_row), .ld_valid(ld_valid), .ld_weight(ld_weight),
    .ld_index(ld_index), .ld_h(ld_h), .ld_done(ld_done), .ld_ack(ld_ack),
    .busy(busy), .done(done), .sample_valid(sample_valid), .sample(sample),
    .sweep_count(sweep_count), .dbg_I(dbg_I)
  );

  pbit_tm_sweep_engine #(.NUM_PBITS(4), .BIPOLAR(1)) u_bip (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .num_sweeps(num_sweeps), .beta(beta), .clamp_en(clamp_en), .clamp_val(clamp_val),
    .ld_start(b_ld_start), .ld_row(b_ld_row), .ld_valid(ld_valid), .ld_weight(ld_weight),
    .ld_index(ld_index), .ld_h(ld_h), .ld_done(ld_done), .ld_ack(b_ld_ack),
    .busy(b_busy), .done(b_done), .sample_valid(b_sample_valid), .sample(b_sample),
    .sweep_count(b_sweep_count), .dbg_I(b_dbg_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx8(input logic [7:0] v);
    return 32'(signed'(v));
  endfunction

  // Row streamer model: answers each ld_start with cfg_nbeats beats, ld_done on the last.
  initial begin : loader
    ld_valid = 1'b0; ld_done = 1'b0; ld_weight = '0; ld_index = '0; ld_h = '0;
    forever begin
      @(posedge clk); #1;
      if (ld_start && reset_n) begin
        @(posedge clk); #1;
        if (cfg_nbeats == 0) begin
          ld_done = 1'b1; ld_h = cfg_h;
          @(posedge clk); #1;
        end else begin
          for (int k = 0; k < cfg_nbeats; k++) begin
            ld_valid = 1'b1; ld_weight = cfg_w; ld_index = cfg_idx;
            if (k == cfg_nbeats - 1) begin ld_done = 1'b1; ld_h = cfg_h; end
            @(posedge clk); #1;
          end
        end
        ld_valid = 1'b0; ld_done = 1'b0;
      end
    end
  end

  task automatic run(input logic [15:0] ns, input int stop_row);
    logic prev_busy, arm, got_ack, pend_dbg;
    res_nsamp = 0; res_ndone = 0; res_nack = 0; res_nrows = 0;
    res_first = 'x; res_last = 'x; res_rows = '0;
    res_busy_done = 1'bx; res_busy_before = 1'bx;
    res_dbg0 = 'x; res_dbg0_b = 'x;
    arm = 1'b0; got_ack = 1'b0; pend_dbg = 1'b0;
    num_sweeps = ns;
    start = 1'b1;
    for (int c = 0; c < 3000 && res_ndone == 0; c++) begin
      prev_busy = busy;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = arm;
      arm   = 1'b0;
      if (pend_dbg) begin res_dbg0 = dbg_I; res_dbg0_b = b_dbg_I; pend_dbg = 1'b0; end
      if (ld_ack) begin
        res_nack++;
        if (!got_ack) begin got_ack = 1'b1; pend_dbg = 1'b1; end
      end
      if (ld_start) begin
        if (res_nrows < 4) res_rows[2*res_nrows +: 2] = ld_row;
        res_nrows++;
        if (ld_row == 2'(stop_row) && stop_row >= 0 && res_nrows <= 4) arm = 1'b1;
      end
      if (sample_valid) begin
        res_nsamp++;
        if (res_nsamp == 1) res_first = sample;
        res_last = sample;
      end
      if (done) begin
        res_ndone++; res_busy_done = busy; res_busy_before = prev_busy;
      end
    end
    stop = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) res_ndone++;
    end
  endtask

  initial begin : main
    int n_ls, n_dn;
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; num_sweeps = '0;
    beta = BETA_ONE; clamp_en = '0; clamp_val = '0;
    repeat (3) @(posedge clk); #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_sample", 32'(sample), 32'd0);
    check_eq("rst_dbg_I", 32'(dbg_I), 32'd0);
    check_eq("rst_sweep_count", 32'(sweep_count), 32'd0);
    check_eq("rst_pulses", 32'({ld_start, ld_ack, done, sample_valid}), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Bounded run, no weights, maximal positive bias
    cfg_nbeats = 0; cfg_h = 9'd255;
    run(16'd3, -1);
    check_eq("t1_dbg_I", sx8(dbg_I), 32'd127);
    check_eq("t1_dbg_I_bip", sx8(b_dbg_I), 32'd127);
    check_eq("t1_first_sample", 32'(res_first), 32'hF);
    check_eq("t1_nsamp", 32'(res_nsamp), 32'd3);
    check_eq("t1_ndone", 32'(res_ndone), 32'd1);
    check_eq("t1_sweep_count", 32'(sweep_count), 32'd3);
    check_eq("t1_nack", 32'(res_nack), 32'd12);
    check_eq("t1_row_order", 32'(res_rows), 32'hE4);
    check_eq("t1_busy_at_done", 32'(res_busy_done), 32'd0);

    // Clamping; a stop pulse while idle must be ignored
    clamp_en = 4'b0101; clamp_val = 4'b0001;
    stop = 1'b1; @(posedge clk); #1; stop = 1'b0;
    run(16'd2, -1);
    check_eq("t2_first_sample", 32'(res_first), 32'hB);
    check_eq("t2_last_sample", 32'(res_last), 32'hB);
    check_eq("t2_nsamp", 32'(res_nsamp), 32'd2);
    check_eq("t2_sweep_count", 32'(sweep_count), 32'd2);

    // 70 beats of +127 on an active column: accumulator must saturate, not wrap
    clamp_en = '0; clamp_val = '0;
    cfg_nbeats = 70; cfg_w = 8'd127; cfg_idx = 2'd0; cfg_h = 9'd0;
    run(16'd1, -1);
    check_eq("t3_dbg_I_row0", sx8(res_dbg0), 32'd127);
    check_eq("t3_dbg_I_bip_row0", sx8(res_dbg0_b), 32'd127);
    check_eq("t3_dbg_I_last", sx8(dbg_I), 32'd127);
    check_eq("t3_sample", 32'(sample), 32'hF);

    // beta = 0 forces zero activation
    cfg_nbeats = 0; cfg_h = 9'd255; beta = 8'd0;
    run(16'd1, -1);
    check_eq("t4_dbg_I_beta0", sx8(dbg_I), 32'd0);

    // beta = 0.5, h = -100 -> -50
    beta = 8'd4; cfg_h = 9'(-100);
    run(16'd1, -1);
    check_eq("t5_dbg_I", sx8(res_dbg0), 32'(-50));
    check_eq("t5_dbg_I_bip", sx8(res_dbg0_b), 32'(-50));

    // Continuous run stopped during row 2: finishes the sweep, then ends
    beta = BETA_ONE; cfg_h = 9'd255;
    run(16'd0, 2);
    check_eq("t6_nsamp", 32'(res_nsamp), 32'd1);
    check_eq("t6_ndone", 32'(res_ndone), 32'd1);
    check_eq("t6_sweep_count", 32'(sweep_count), 32'd1);
    check_eq("t6_busy_at_done", 32'(res_busy_done), 32'd0);
    check_eq("t6_busy_before_done", 32'(res_busy_before), 32'd1);
    check_eq("t6_sample", 32'(sample), 32'hF);

    // Asynchronous reset in the middle of ACCUM
    cfg_nbeats = 70; cfg_w = 8'd1; cfg_idx = 2'd0; cfg_h = 9'd0;
    num_sweeps = 16'd1;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 20 && !ld_start; c++) begin @(posedge clk); #1; end
    check_eq("t7_ld_start_seen", 32'(ld_start), 32'd1);
    repeat (5) @(posedge clk); #1;
    check_eq("t7_busy_pre", 32'(busy), 32'd1);
    #2 reset_n = 1'b0; #1;
    check_eq("t7_busy", 32'(busy), 32'd0);
    check_eq("t7_sample", 32'(sample), 32'd0);
    check_eq("t7_dbg_I", 32'(dbg_I), 32'd0);
    check_eq("t7_sweep_count", 32'(sweep_count), 32'd0);
    check_eq("t7_pulses", 32'({ld_start, ld_ack, done, sample_valid}), 32'd0);
    @(posedge clk); #1; reset_n = 1'b1;
    n_ls = 0; n_dn = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (ld_start) n_ls++;
      if (done) n_dn++;
    end
    check_eq("t7_idle_no_request", 32'(n_ls), 32'd0);
    check_eq("t7_no_done", 32'(n_dn), 32'd0);

    // Bipolar term: m = 0 after reset, J = +5 contributes -5 only in bipolar mode
    cfg_nbeats = 1; cfg_w = 8'd5; cfg_idx = 2'd0; cfg_h = 9'd0; beta = BETA_ONE;
    run(16'd1, -1);
    check_eq("t8_dbg_I_unipolar", sx8(res_dbg0), 32'd0);
    check_eq("t8_dbg_I_bipolar", sx8(res_dbg0_b), 32'(-5));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule

// File: doc/pbit_tm_sweep_engine.md
Name: pbit_tm_sweep_engine

Overview:
- Parametrised successor to the single-lane time-multiplexed p-bit controller.
- Sequentially updates NUM_PBITS p-bits, one row at a time, from a sparse weight/bias row streamer.
- Adds runtime beta (I0) scaling, per-p-bit clamping, an optional bipolar spin mode, bounded or continuous sweep runs with start/stop/done, and a per-sweep sample output.
- Sits between the weight loader and the histogram/ILA logger.

Parameters:
- NUM_PBITS, 16, number of time-multiplexed p-bits.
- W_W, 8, signed weight width.
- H_W, 9, signed bias width.
- ACC_W, 14, signed accumulator width.
- I_W, 8, signed activation width, which is also the comparison width.
- BETA_W, 8, unsigned beta width.
- BETA_FRAC, 3, beta fractional bits; 8'd8 = 1.0.
- SWEEP_W, 16, sweep counter width.
- BIPOLAR, 0, m encoding: 0 = {0,1}, 1 = {-1,+1}.
- SEED, 32'hACE1_2468, RNG seed; must be non-zero.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- start  in  1  begin a run; ignored while busy.
- stop  in  1  request stop; honoured at the next sweep boundary.
- num_sweeps  in  SWEEP_W  sweeps per run; 0 = continuous. Sampled at start.
- beta  in  BETA_W  inverse temperature. Sampled once per row in COMPUTE.
- clamp_en  in  NUM_PBITS  per-p-bit clamp enable.
- clamp_val  in  NUM_PBITS  forced value for clamped p-bits.
- ld_start  out  1  one-cycle row request.
- ld_row  out  $clog2(NUM_PBITS)  requested row.
- ld_valid  in  1  weight beat valid.
- ld_weight  in  W_W  signed J_ij.
- ld_index  in  $clog2(NUM_PBITS)  column j.
- ld_h  in  H_W  row bias; valid while ld_done is high.
- ld_done  in  1  row complete.
- ld_ack  out  1  one-cycle pulse: row consumed.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- sample_valid  out  1  one-cycle pulse per completed sweep.
- sample  out  NUM_PBITS  m vector snapshot.
- sweep_count  out  SWEEP_W  completed sweeps this run.
- dbg_I  out  I_W  last saturated activation.

Behaviour:
- Reset is asynchronous and active-low, single clock domain. On reset:
  - State IDLE; m, sample and dbg_I cleared to 0.
  - All pulses and busy at 0; sweep_count 0; RNG reloaded to SEED.
  - Reset mid-run aborts the run; no done pulse is issued.
- FSM: IDLE -> LOAD_REQ -> ACCUM -> COMPUTE -> UPDATE -> (LOAD_REQ | IDLE).
- IDLE:
  - start=1 latches num_sweeps, clears sweep_count and the row counter, sets busy, and moves to LOAD_REQ.
- LOAD_REQ:
  - Drives ld_start=1 and ld_row=row for one cycle; clears acc.
- ACCUM:
  - Each ld_valid adds term = m[j] ? J : (BIPOLAR ? -J : 0), sign-extended to ACC_W.
  - Terms that would exceed the ACC_W range saturate; acc never wraps.
  - ld_valid and ld_done high in the same cycle: accumulate that beat, then exit.
  - On ld_done: latch ld_h, pulse ld_ack, go to COMPUTE.
- COMPUTE (1 cycle), all arithmetic signed:
  - s1 = sat(acc) to H_W+1 bits.
  - s2 = sat(s1 + h) to I_W bits.
  - p = s2 * {0,beta}, full width, then arithmetic shift right by BETA_FRAC.
  - I = sat(p) to I_W bits; register into dbg_I.
  - Saturation bounds are [-2^(n-1), 2^(n-1)-1].
- UPDATE (1 cycle):
  - r = low I_W bits of the RNG, interpreted as signed.
  - m_new = (I >= r). The RNG advances once per UPDATE.
  - If clamp_en[row] is set, m[row] <= clamp_val[row] instead.
  - If row < NUM_PBITS-1: row++, go to LOAD_REQ.
  - Otherwise (sweep end): sample <= updated m including this row; sample_valid=1; sweep_count++; row=0. Then:
    - If (num_sweeps != 0 and sweep_count+1 == num_sweeps) or stop is pending: done=1, busy=0, go to IDLE.
    - Else go to LOAD_REQ.
- stop is sticky from assertion until the sweep boundary. stop asserted in IDLE is ignored.
- Latency per p-bit: 1 (LOAD_REQ) + loader cycles + 1 (COMPUTE) + 1 (UPDATE).
- sweep_count saturates at all-ones in continuous mode.
- m changes only in UPDATE. Rows later in the same sweep see updated earlier p-bits (Gibbs order).

Decomposition:
- Package pbit_pkg: state_t enum, sat() function, BETA_ONE localparam.
- Sub-module pbit_xorshift32: xorshift32 RNG with enable, SEED parameter, and reset_n.

Test Plan:
- NUM_PBITS=4, no weights, ld_h=+255, beta=8, num_sweeps=3 -> dbg_I=127; m=4'b1111 after sweep 1; 3 sample_valid pulses; done once; sweep_count=3.
- clamp_en=4'b0101, clamp_val=4'b0001, h=+255 -> sample=4'b1011 every sweep.
- Row of 20 weights of +127 with all m=1, h=0 -> acc saturates to 2047 (ACC_W=12 variant); dbg_I=127, no wrap.
- beta=0 -> dbg_I=0. beta=4 (0.5), h=-100, no weights -> dbg_I=-50.
- num_sweeps=0, stop pulsed mid-row 2 -> run finishes row 3; one sample_valid; done; busy falls the same cycle.
- reset_n low during ACCUM -> all outputs 0 and state IDLE. BIPOLAR=1, m=0, J=+5 -> term -5 verified via dbg_I.
